sha1_core: RTL and testbench



---
 rtl/sha1_core.sv | 129 ++++++++++++
 tb/tb_sha1_core.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sha1_core.sv
// sha1_core: one SHA-1 block compression, one round per clock.
// The macro SHA1_CHAIN_EN adds chain_i so multi-block messages can continue
// from the current H registers. Without it, every block starts from IV.
module sha1_core #(
    parameter logic [159:0] IV = 160'hC3D2E1F0_10325476_98BADCFE_EFCDAB89_67452301
) (
    input  logic         wb_clk_i,
    input  logic         reset,
    input  logic         start,
    input  logic         clear,
`ifdef SHA1_CHAIN_EN
    input  logic         chain_i,
`endif
    input  logic [511:0] message_i,
    output logic [159:0] digest_o,
    output logic         busy,
    output logic         done,
    output logic         panic,
    output logic [6:0]   loop_idx
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUND = 2'd1;
    localparam logic [1:0] FINAL = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]        state;
    logic [4:0][31:0]  h;       // h[0] = H0
    logic [15:0][31:0] w;       // w[0] = W[t] of the current round
    logic [31:0]       a, b, c, d, e;

    logic [31:0]       f, k, temp, w_new;
    logic [4:0][31:0]  h_sum, init;
    logic              accept, use_h;

`ifdef SHA1_CHAIN_EN
    // In IDLE the H registers already hold IV, so chain_i alone decides.
    assign use_h = chain_i;
`else
    assign use_h = 1'b0;
`endif

    // clear outranks start; start is only taken when no block is in flight
    assign accept = start && !clear && (state == IDLE || state == DONE);
    assign init   = use_h ? h : IV;

    // Round function, constant, schedule extension and final addition
    always_comb begin
        f = b ^ c ^ d;
        k = 32'hCA62C1D6;
        if (loop_idx < 7'd20) begin
            f = (b & c) | (~b & d);
            k = 32'h5A827999;
        end else if (loop_idx < 7'd40) begin
            k = 32'h6ED9EBA1;
        end else if (loop_idx < 7'd60) begin
            f = (b & c) | (b & d) | (c & d);
            k = 32'h8F1BBCDC;
        end
        temp  = {a[26:0], a[31:27]} + f + e + k + w[0];
        w_new = w[13] ^ w[8] ^ w[2] ^ w[0];
        w_new = {w_new[30:0], w_new[31]};
        h_sum[0] = h[0] + a;
        h_sum[1] = h[1] + b;
        h_sum[2] = h[2] + c;
        h_sum[3] = h[3] + d;
        h_sum[4] = h[4] + e;
    end

    // Control FSM, working variables, schedule window and hash state
    always_ff @(posedge wb_clk_i) begin
        if (reset) begin
            state    <= IDLE;
            h        <= IV;
            w        <= '0;
            {a, b, c, d, e} <= '0;
            digest_o <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            panic    <= 1'b0;
            loop_idx <= '0;
        end else if (clear) begin
            state    <= IDLE;
            h        <= IV;
            busy     <= 1'b0;
            done     <= 1'b0;
            panic    <= 1'b0;
            loop_idx <= '0;
        end else begin
            if (start && busy)
                panic <= 1'b1;
            if (accept) begin
                state    <= ROUND;
                h        <= init;
                w        <= message_i;
                a        <= init[0];
                b        <= init[1];
                c        <= init[2];
                d        <= init[3];
                e        <= init[4];
                loop_idx <= '0;
                busy     <= 1'b1;
                done     <= 1'b0;
            end else begin
                case (state)
                    ROUND: begin
                        e <= d;
                        d <= c;
                        c <= {b[1:0], b[31:2]};
                        b <= a;
                        a <= temp;
                        w <= {w_new, w[15:1]};
                        if (loop_idx == 7'd79)
                            state <= FINAL;
                        else
                            loop_idx <= loop_idx + 7'd1;
                    end
                    FINAL: begin
                        h        <= h_sum;
                        digest_o <= h_sum;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sha1_core.sv
// tb_sha1_core: directed SHA-1 vectors and protocol corner cases for sha1_core.
module tb_sha1_core;
    logic         wb_clk_i = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         clear = 1'b0;
`ifdef SHA1_CHAIN_EN
    logic         chain_i = 1'b0;
`endif
    logic [511:0] message_i = '0;
    logic [159:0] digest_o;
    logic         busy, done, panic;
    logic [6:0]   loop_idx;

    int checks = 0;
    int errors = 0;

    localparam logic [511:0] MSG_ABC   = {32'h00000018, 448'h0, 32'h61626380};
    localparam logic [511:0] MSG_EMPTY = {480'h0, 32'h80000000};
    localparam logic [159:0] DIG_ABC   =
        {32'h9CD0D89D, 32'h7850C26C, 32'hBA3E2571, 32'h4706816A, 32'hA9993E36};
    localparam logic [159:0] DIG_EMPTY =
        {32'hAFD80709, 32'h95601890, 32'h3255BFEF, 32'h5E6B4B0D, 32'hDA39A3EE};

    sha1_core dut (
        .wb_clk_i (wb_clk_i),
        .reset    (reset),
        .start    (start),
        .clear    (clear),
`ifdef SHA1_CHAIN_EN
        .chain_i  (chain_i),
`endif
        .message_i(message_i),
        .digest_o (digest_o),
        .busy     (busy),
        .done     (done),
        .panic    (panic),
        .loop_idx (loop_idx)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Called at a negedge; returns at the negedge after the sampling edge.
    task automatic start_block(input logic [511:0] msg);
        message_i = msg;
        start = 1'b1;
        @(negedge wb_clk_i);
        start = 1'b0;
        message_i = {16{32'hDEADBEEF}};
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge wb_clk_i);
        clear = 1'b0;
    endtask

    // Edges counted from the start edge until done; 200 means timeout.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 200) begin
            @(negedge wb_clk_i);
            cyc++;
        end
    endtask

    task automatic wait_idx(input logic [6:0] idx, output bit ok);
        int n = 0;
        while (loop_idx !== idx && n < 200) begin
            @(negedge wb_clk_i);
            n++;
        end
        ok = (loop_idx === idx);
    endtask

    task automatic test_reset();
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        checks++; if (digest_o !== 160'h0) begin errors++; $display("FAIL rst_digest got %h want 0", digest_o); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
        checks++; if (panic !== 1'b0) begin errors++; $display("FAIL rst_panic got %b want 0", panic); end
        checks++; if (loop_idx !== 7'd0) begin errors++; $display("FAIL rst_idx got %0d want 0", loop_idx); end
        reset = 1'b0;
        @(negedge wb_clk_i);
    endtask

    task automatic test_abc();
        int cyc;
        start_block(MSG_ABC);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abc_busy got %b want 1", busy); end
        wait_done(cyc);
        checks++; if (cyc != 81) begin errors++; $display("FAIL abc_latency got %0d want 81", cyc); end
        checks++; if (digest_o !== DIG_ABC) begin errors++; $display("FAIL abc_digest got %h want %h", digest_o, DIG_ABC); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abc_busy_end got %b want 0", busy); end
        checks++; if (loop_idx !== 7'd79) begin errors++; $display("FAIL abc_idx got %0d want 79", loop_idx); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        start_block(MSG_EMPTY);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_drop got %b want 0", done); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b want 1", busy); end
        wait_done(cyc);
        checks++; if (cyc != 81) begin errors++; $display("FAIL b2b_latency got %0d want 81", cyc); end
        checks++; if (digest_o !== DIG_EMPTY) begin errors++; $display("FAIL empty_digest got %h want %h", digest_o, DIG_EMPTY); end
    endtask

    task automatic test_busy_start();
        int cyc;
        bit ok;
        start_block(MSG_ABC);
        wait_idx(7'd40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL busy_reach40 got %0d want 40", loop_idx); end
        start_block(MSG_EMPTY);
        checks++; if (panic !== 1'b1) begin errors++; $display("FAIL busy_panic got %b want 1", panic); end
        checks++; if (loop_idx !== 7'd41) begin errors++; $display("FAIL busy_idx got %0d want 41", loop_idx); end
        wait_done(cyc);
        checks++; if (digest_o !== DIG_ABC) begin errors++; $display("FAIL busy_digest got %h want %h", digest_o, DIG_ABC); end
        pulse_clear();
        checks++; if (panic !== 1'b0) begin errors++; $display("FAIL clr_panic got %b want 0", panic); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL clr_done got %b want 0", done); end
        checks++; if (digest_o !== DIG_ABC) begin errors++; $display("FAIL clr_digest got %h want %h", digest_o, DIG_ABC); end
    endtask

    task automatic test_clear();
        int cyc;
        bit ok;
        bit seen = 1'b0;
        start_block(MSG_EMPTY);
        wait_idx(7'd10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL clr_reach10 got %0d want 10", loop_idx); end
        pulse_clear();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midclr_busy got %b want 0", busy); end
        checks++; if (loop_idx !== 7'd0) begin errors++; $display("FAIL midclr_idx got %0d want 0", loop_idx); end
        for (int i = 0; i < 100; i++) begin
            @(negedge wb_clk_i);
            if (done === 1'b1) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL midclr_nodone got 1 want 0"); end
        start_block(MSG_ABC);
        wait_done(cyc);
        checks++; if (digest_o !== DIG_ABC || cyc != 81) begin errors++; $display("FAIL postclr_digest got %h/%0d want %h/81", digest_o, cyc, DIG_ABC); end
    endtask

    task automatic test_start_clear();
        pulse_clear();
        start = 1'b1;
        clear = 1'b1;
        message_i = MSG_ABC;
        @(negedge wb_clk_i);
        start = 1'b0;
        clear = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sc_busy got %b want 0", busy); end
        repeat (3) @(negedge wb_clk_i);
        checks++; if (busy !== 1'b0 || loop_idx !== 7'd0) begin errors++; $display("FAIL sc_idle got busy=%b idx=%0d want 0/0", busy, loop_idx); end
        checks++; if (panic !== 1'b0) begin errors++; $display("FAIL sc_panic got %b want 0", panic); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL sc_done got %b want 0", done); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        start_block(MSG_ABC);
        wait_idx(7'd20, ok);
        start_block(MSG_ABC);
        checks++; if (!ok || panic !== 1'b1) begin errors++; $display("FAIL rm_setup got idx_ok=%b panic=%b want 1/1", ok, panic); end
        reset = 1'b1;
        @(negedge wb_clk_i);
        reset = 1'b0;
        checks++; if (digest_o !== 160'h0) begin errors++; $display("FAIL rm_digest got %h want 0", digest_o); end
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rm_flags got done=%b busy=%b want 0/0", done, busy); end
        checks++; if (panic !== 1'b0) begin errors++; $display("FAIL rm_panic got %b want 0", panic); end
        checks++; if (loop_idx !== 7'd0) begin errors++; $display("FAIL rm_idx got %0d want 0", loop_idx); end
    endtask

`ifdef SHA1_CHAIN_EN
    task automatic test_chain();
        int cyc;
        logic [511:0] m1;
        logic [7:0] ch;
        localparam logic [159:0] DIG_2BLK =
            {32'hE54670F1, 32'hF95129E5, 32'hBAAE4AA1, 32'h1C3BD26E, 32'h84983E44};
        m1 = '0;
        for (int i = 0; i < 14; i++) begin
            ch = 8'h61 + 8'(i);
            m1[32*i +: 32] = {ch, ch + 8'd1, ch + 8'd2, ch + 8'd3};
        end
        m1[32*14 +: 32] = 32'h80000000;
        chain_i = 1'b0;
        start_block(m1);
        wait_done(cyc);
        chain_i = 1'b1;
        start_block({32'h000001C0, 480'h0});
        chain_i = 1'b0;
        wait_done(cyc);
        checks++; if (digest_o !== DIG_2BLK) begin errors++; $display("FAIL chain_digest got %h want %h", digest_o, DIG_2BLK); end
    endtask
`endif

    initial begin
        test_reset();
        test_abc();
        test_back_to_back();
        test_busy_start();
        test_clear();
        test_start_clear();
        test_reset_mid();
`ifdef SHA1_CHAIN_EN
        test_chain();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
